rtc_lectura: RTL and testbench



---
 rtl/rtc_lectura.sv | 226 ++++++++++++++++++++++
 tb/tb_rtc_lectura.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_lectura.sv
// ---------------------------------------------------------------------------
// rtc_lectura
//
// Periodic read sweeper for the RTC time/date/timer registers. It is the
// read-side partner of the user programming FSM. After every idle period it
// reads the nine registers, one at a time, through the bus-cycle engine.
// It keeps the bytes in a shadow bank. A sweep is published to the display
// path only when all nine bytes arrived as valid BCD and reading stayed
// enabled the whole time. The publish is atomic and comes with a one-cycle
// update strobe.
//
// Parameters
//   PERIOD_CYCLES   idle cycles between the end of one sweep and the next
//                   (minimum 2)
//   TIMEOUT_CYCLES  maximum cycles a request may wait for rd_ack before the
//                   sweep is abandoned (minimum 1)
//
// Ports
//   clk       system clock, all state changes on its rising edge
//   reset     synchronous, active-high reset
//   enable    sweeps permitted; low while the user is programming
//   rd_req    read request to the bus-cycle engine
//   rd_addr   RTC register address, stable while rd_req is high
//   rd_ack    engine read complete; rd_data valid in the same cycle
//   rd_data   read byte (BCD)
//   rsegr, rminr, rhorar, diar, mesr, annor, tsegr, tminr, thorar
//             published BCD values
//   update    one-cycle pulse on the cycle the published values change
//   busy      high from sweep start until commit or abort
//   err       sticky: timeout or invalid BCD seen; cleared only by reset
// ---------------------------------------------------------------------------
module rtc_lectura #(
    parameter int PERIOD_CYCLES  = 1000000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic       rd_ack,
    input  logic [7:0] rd_data,
    output logic [7:0] rsegr,
    output logic [7:0] rminr,
    output logic [7:0] rhorar,
    output logic [7:0] diar,
    output logic [7:0] mesr,
    output logic [7:0] annor,
    output logic [7:0] tsegr,
    output logic [7:0] tminr,
    output logic [7:0] thorar,
    output logic       update,
    output logic       busy,
    output logic       err
);

    // The period counter only has to reach PERIOD_CYCLES-1.
    // The timeout counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX = 4'd8;

    typedef enum logic [2:0] {
        S_WAIT,
        S_REQ,
        S_GAP,
        S_COMMIT,
        S_ABORT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] per_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       idx;
    logic             sweep_bad;

    logic [7:0] shadow [9];
    logic [7:0] pub    [9];

    // Register address for each sweep slot.
    // Slots 0-5 hold the clock and calendar. Slots 6-8 hold the timer.
    function automatic logic [7:0] addr_of(input logic [3:0] i);
        logic [7:0] a;
        case (i)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            default: a = 8'h43;
        endcase
        return a;
    endfunction

    // A byte is valid BCD when neither nibble exceeds 9.
    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // Shadow bank: plain data, captured only on an acknowledged request.
    // It is never published until a full sweep has refilled all nine slots.
    // That is why it needs no reset.
    always_ff @(posedge clk) begin
        if (!reset && state == S_REQ && rd_ack) begin
            shadow[idx] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_WAIT;
            per_cnt   <= '0;
            to_cnt    <= '0;
            idx       <= '0;
            sweep_bad <= 1'b0;
            rd_req    <= 1'b0;
            rd_addr   <= 8'h00;
            update    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            // Day and month reset to 01 so the display never shows a date of 00.
            for (int i = 0; i < 9; i++) begin
                pub[i] <= (i == 3 || i == 4) ? 8'h01 : 8'h00;
            end
        end else begin
            update <= 1'b0;
            case (state)
                S_WAIT: begin
                    // The counter saturates at PER_LAST.
                    // A held-off sweep then starts on the first cycle enable is high.
                    if (per_cnt == PER_LAST) begin
                        if (enable) begin
                            state     <= S_REQ;
                            per_cnt   <= '0;
                            to_cnt    <= '0;
                            idx       <= '0;
                            sweep_bad <= 1'b0;
                            busy      <= 1'b1;
                            rd_req    <= 1'b1;
                            rd_addr   <= addr_of(4'd0);
                        end
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                    end
                end

                S_REQ: begin
                    // An outstanding request is never withdrawn because of enable.
                    // It finishes here by ack or timeout. The GAP state then
                    // decides whether to abort.
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        state  <= S_GAP;
                        if (!bcd_ok(rd_data)) begin
                            err       <= 1'b1;
                            sweep_bad <= 1'b1;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        err     <= 1'b1;
                        rd_req  <= 1'b0;
                        busy    <= 1'b0;
                        per_cnt <= '0;
                        state   <= S_ABORT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_GAP: begin
                    // One mandatory idle cycle between requests.
                    if (!enable || sweep_bad) begin
                        busy  <= 1'b0;
                        state <= S_ABORT;
                    end else if (idx == LAST_IDX) begin
                        // The publish happens on this edge, together with update.
                        // The new values are therefore visible during the
                        // update cycle itself.
                        for (int i = 0; i < 9; i++) begin
                            pub[i] <= shadow[i];
                        end
                        update <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_COMMIT;
                    end else begin
                        idx     <= idx + 4'd1;
                        to_cnt  <= '0;
                        rd_req  <= 1'b1;
                        rd_addr <= addr_of(idx + 4'd1);
                        state   <= S_REQ;
                    end
                end

                S_COMMIT: begin
                    per_cnt <= '0;
                    state   <= S_WAIT;
                end

                S_ABORT: begin
                    per_cnt <= '0;
                    state   <= S_WAIT;
                end

                default: begin
                    state <= S_WAIT;
                end
            endcase
        end
    end

    assign rsegr  = pub[0];
    assign rminr  = pub[1];
    assign rhorar = pub[2];
    assign diar   = pub[3];
    assign mesr   = pub[4];
    assign annor  = pub[5];
    assign tsegr  = pub[6];
    assign tminr  = pub[7];
    assign thorar = pub[8];

endmodule

// File: tb/tb_rtc_lectura.sv
// ---------------------------------------------------------------------------
// tb_rtc_lectura
//
// Bench for rtc_lectura with PERIOD_CYCLES=4 and TIMEOUT_CYCLES=8.
// A bus responder answers each request after a random delay with random BCD.
// Stray acks and garbage data are driven while no request is outstanding.
// A sweep-level model tracks the published bank, the sticky error and the
// number of update pulses expected.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rtc_lectura;

    localparam int PER = 4;
    localparam int TO  = 8;
    localparam int CLK_NS = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_data;
    logic [7:0] rsegr, rminr, rhorar, diar, mesr, annor, tsegr, tminr, thorar;
    logic       update;
    logic       busy;
    logic       err;

    always #(CLK_NS / 2) clk = ~clk;

    rtc_lectura #(
        .PERIOD_CYCLES (PER),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .rd_req (rd_req),
        .rd_addr(rd_addr),
        .rd_ack (rd_ack),
        .rd_data(rd_data),
        .rsegr  (rsegr),
        .rminr  (rminr),
        .rhorar (rhorar),
        .diar   (diar),
        .mesr   (mesr),
        .annor  (annor),
        .tsegr  (tsegr),
        .tminr  (tminr),
        .thorar (thorar),
        .update (update),
        .busy   (busy),
        .err    (err)
    );

    logic [7:0] outv [9];
    always_comb begin
        outv[0] = rsegr;
        outv[1] = rminr;
        outv[2] = rhorar;
        outv[3] = diar;
        outv[4] = mesr;
        outv[5] = annor;
        outv[6] = tsegr;
        outv[7] = tminr;
        outv[8] = thorar;
    end

    logic [7:0] ADDR [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    // Reference model state
    logic [7:0] exp_pub [9];
    bit         exp_err = 1'b0;
    int         exp_upd = 0;
    int         upd_seen = 0;

    // Per-sweep stimulus
    int         dly [9];
    logic [7:0] dat [9];
    int         noack_idx  = -1;
    int         endrop_idx = -1;
    int         rst_idx    = -1;

    bit  have_end = 1'b0;
    time t_end = 0;

    int n_tests = 0;
    int n_fail  = 0;

    always @(negedge clk) begin
        if (update === 1'b1) upd_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit bcd_ok(input logic [7:0] b);
        return (b[7:4] < 4'd10) && (b[3:0] < 4'd10);
    endfunction

    task automatic set_reset_model();
        for (int i = 0; i < 9; i++) exp_pub[i] = (i == 3 || i == 4) ? 8'h01 : 8'h00;
        exp_err = 1'b0;
    endtask

    task automatic chk_outs(input string tag);
        for (int i = 0; i < 9; i++) chk($sformatf("%s_out%0d", tag, i), outv[i], exp_pub[i]);
    endtask

    task automatic setup(input int maxd);
        for (int i = 0; i < 9; i++) begin
            dly[i] = int'($urandom_range(0, maxd));
            dat[i] = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
    endtask

    // Waits at negedges for a request.
    // Stray acks are driven meanwhile and must be ignored.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (rd_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            rd_ack  = ($urandom_range(0, 3) == 0);
            rd_data = 8'($urandom);
            @(negedge clk);
        end
        rd_ack = 1'b0;
        if (!ok) chk("req_wait_expired", 32'd0, 32'd1);
        else if (have_end) chk("period", int'(($time - t_end) / CLK_NS), PER + 1);
    endtask

    task automatic do_sweep();
        bit  ok;
        bit  abort_sw;
        time t0;
        int  sumd;
        wait_req(ok);
        if (!ok) return;
        t0 = $time;
        sumd = 0;
        abort_sw = 1'b0;
        chk("busy_start", busy, 1);
        chk("err_start", err, exp_err);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) chk("req_after_gap", rd_req, 1);
            chk($sformatf("addr%0d", i), rd_addr, ADDR[i]);
            if (i == rst_idx) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                set_reset_model();
                have_end = 1'b0;
                chk("rst_req", rd_req, 0);
                chk("rst_busy", busy, 0);
                chk("rst_err", err, 0);
                chk("rst_addr", rd_addr, 0);
                chk("rst_upd", update, 0);
                chk_outs("rst");
                return;
            end
            if (i == noack_idx) begin
                for (int k = 0; k < TO; k++) begin
                    chk("to_hold", rd_req, 1);
                    rd_data = 8'($urandom);
                    @(negedge clk);
                end
                exp_err = 1'b1;
                chk("to_drop", rd_req, 0);
                chk("to_err", err, 1);
                chk("to_busy", busy, 0);
                abort_sw = 1'b1;
                break;
            end
            if (i == endrop_idx) enable = 1'b0;
            for (int k = 0; k < dly[i]; k++) begin
                rd_data = 8'($urandom);
                @(negedge clk);
                chk("hold_req", rd_req, 1);
                chk("hold_addr", rd_addr, ADDR[i]);
            end
            sumd += dly[i];
            rd_ack  = 1'b1;
            rd_data = dat[i];
            @(negedge clk);
            rd_ack  = 1'b0;
            rd_data = 8'($urandom);
            chk("gap_req", rd_req, 0);
            if (!bcd_ok(dat[i])) exp_err = 1'b1;
            chk("err", err, exp_err);
            if (!bcd_ok(dat[i]) || i == endrop_idx) begin
                abort_sw = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        t_end = $time;
        have_end = 1'b1;
        if (abort_sw) begin
            chk("abort_req", rd_req, 0);
            chk("abort_busy", busy, 0);
            chk("abort_upd", update, 0);
            @(negedge clk);
            chk_outs("abort");
            chk("abort_updcnt", upd_seen, exp_upd);
        end else begin
            for (int i = 0; i < 9; i++) exp_pub[i] = dat[i];
            exp_upd++;
            chk("upd", update, 1);
            // With no ack delays the pulse is in the 19th cycle, counting REQ entry as cycle 1.
            chk("latency", int'(($time - t0) / CLK_NS), 18 + sumd);
            chk("commit_busy", busy, 0);
            chk("commit_req", rd_req, 0);
            chk("commit_err", err, exp_err);
            chk_outs("commit");
            @(negedge clk);
            chk("upd_single", update, 0);
            chk("updcnt", upd_seen, exp_upd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit idle_bad;
        reset   = 1'b1;
        enable  = 1'b0;
        rd_ack  = 1'b0;
        rd_data = 8'h00;
        set_reset_model();
        repeat (3) @(negedge clk);
        chk("rst0_req", rd_req, 0);
        chk("rst0_addr", rd_addr, 0);
        chk("rst0_upd", update, 0);
        chk("rst0_busy", busy, 0);
        chk("rst0_err", err, 0);
        chk_outs("rst0");
        reset = 1'b0;
        idle_bad = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (update !== 1'b0 || rd_req !== 1'b0) idle_bad = 1'b1;
        end
        chk("idle_disabled", idle_bad, 0);
        enable = 1'b1;

        // Directed first sweep, immediate acks
        dat = '{8'h45, 8'h30, 8'h12, 8'h25, 8'h12, 8'h16, 8'h10, 8'h05, 8'h01};
        for (int i = 0; i < 9; i++) dly[i] = 0;
        do_sweep();
        chk("err_clean", err, 0);

        // Every ack 3 cycles late
        setup(0);
        for (int i = 0; i < 9; i++) dly[i] = 3;
        do_sweep();

        repeat (4) begin
            setup(3);
            do_sweep();
        end

        // No ack for slot 2: timeout abort
        setup(2);
        noack_idx = 2;
        do_sweep();
        noack_idx = -1;
        setup(3);
        do_sweep();

        // Invalid BCD in the day slot
        setup(1);
        dat[3] = 8'h3A;
        do_sweep();

        // enable drops while slot 4 is outstanding
        setup(1);
        endrop_idx = 4;
        dly[4] = 2;
        do_sweep();
        endrop_idx = -1;
        idle_bad = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (rd_req !== 1'b0 || busy !== 1'b0 || update !== 1'b0) idle_bad = 1'b1;
        end
        chk("held_off", idle_bad, 0);
        enable = 1'b1;
        have_end = 1'b0;
        setup(3);
        do_sweep();

        // Reset mid-sweep, then a clean sweep
        setup(1);
        rst_idx = 5;
        do_sweep();
        rst_idx = -1;
        setup(3);
        do_sweep();
        chk("final_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
